// File: rtl/mem_arb_pkg.sv
// -----------------------------------------------------------------------------
// mem_arb_pkg
// Shared definitions for the two-requester memory arbiter:
//   - arbiter FSM state encoding (arb_state_e)
//   - default block address / data widths
//   - requester identifiers used by the grant pick and the last-served pointer
// -----------------------------------------------------------------------------
package mem_arb_pkg;

  // Default widths: 28-bit block address (16-byte blocks), 128-bit block.
  localparam int MEM_ARB_ADDR_W  = 28;
  localparam int MEM_ARB_BLOCK_W = 128;

  // Requester identifiers.
  localparam logic REQ_I = 1'b0;
  localparam logic REQ_D = 1'b1;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    GNT_I  = 3'd1,
    GNT_D  = 3'd2,
    DONE_I = 3'd3,
    DONE_D = 3'd4
  } arb_state_e;

endpackage

// File: rtl/mem_arbiter_if.sv
// -----------------------------------------------------------------------------
// mem_arbiter_if
// Bundles the instruction-side, data-side and shared memory-port signals of the
// arbiter.
//   I side  : I_READ, I_ADDR          -> I_BUSYWAIT, I_READDATA
//   D side  : D_READ, D_WRITE, D_ADDR, D_WRITEDATA -> D_BUSYWAIT, D_READDATA
//   Memory  : MEM_READ, MEM_WRITE, MEM_ADDR, MEM_WRITEDATA -> memory
//             MEM_READDATA, MEM_BUSYWAIT <- memory
// Modports:
//   slave  : the arbiter's view
//   master : the surrounding environment (requesters plus memory)
// Handshake: a requester raises its request and holds it while its BUSYWAIT is
// high; the single cycle with BUSYWAIT low marks completion, with read data
// valid on x_READDATA in that cycle. The memory holds MEM_BUSYWAIT high while
// it is not done; the first command cycle with MEM_BUSYWAIT low completes it.
// -----------------------------------------------------------------------------
interface mem_arbiter_if
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W  = MEM_ARB_ADDR_W,
  parameter int BLOCK_W = MEM_ARB_BLOCK_W
) ();

  logic               I_READ;
  logic [ADDR_W-1:0]  I_ADDR;
  logic               I_BUSYWAIT;
  logic [BLOCK_W-1:0] I_READDATA;

  logic               D_READ;
  logic               D_WRITE;
  logic [ADDR_W-1:0]  D_ADDR;
  logic [BLOCK_W-1:0] D_WRITEDATA;
  logic               D_BUSYWAIT;
  logic [BLOCK_W-1:0] D_READDATA;

  logic               MEM_READ;
  logic               MEM_WRITE;
  logic [ADDR_W-1:0]  MEM_ADDR;
  logic [BLOCK_W-1:0] MEM_WRITEDATA;
  logic [BLOCK_W-1:0] MEM_READDATA;
  logic               MEM_BUSYWAIT;

  modport slave (
    input  I_READ, I_ADDR,
    input  D_READ, D_WRITE, D_ADDR, D_WRITEDATA,
    input  MEM_READDATA, MEM_BUSYWAIT,
    output I_BUSYWAIT, I_READDATA,
    output D_BUSYWAIT, D_READDATA,
    output MEM_READ, MEM_WRITE, MEM_ADDR, MEM_WRITEDATA
  );

  modport master (
    output I_READ, I_ADDR,
    output D_READ, D_WRITE, D_ADDR, D_WRITEDATA,
    output MEM_READDATA, MEM_BUSYWAIT,
    input  I_BUSYWAIT, I_READDATA,
    input  D_BUSYWAIT, D_READDATA,
    input  MEM_READ, MEM_WRITE, MEM_ADDR, MEM_WRITEDATA
  );

endinterface

// File: rtl/mem_arb_pick.sv
// -----------------------------------------------------------------------------
// mem_arb_pick
// Combinational grant selection between the I and D requesters.
// Ports:
//   i_req_i     : I side has a request pending
//   d_req_i     : D side has a request pending
//   last_i      : side served last (REQ_I / REQ_D)
//   gnt_valid_o : some request is pending
//   gnt_side_o  : side to grant (REQ_I / REQ_D), meaningful with gnt_valid_o
// On a tie the side that was not served last wins. Tying last_i to REQ_I
// turns this into fixed D-over-I priority.
// -----------------------------------------------------------------------------
module mem_arb_pick
  import mem_arb_pkg::*;
(
  input  logic i_req_i,
  input  logic d_req_i,
  input  logic last_i,
  output logic gnt_valid_o,
  output logic gnt_side_o
);

  always_comb begin
    gnt_valid_o = i_req_i | d_req_i;
    gnt_side_o  = REQ_D;
    if (i_req_i && d_req_i) begin
      gnt_side_o = (last_i == REQ_D) ? REQ_I : REQ_D;
    end else if (i_req_i) begin
      gnt_side_o = REQ_I;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
// Shares one block-wide memory port between an instruction-side reader and a
// data-side reader/writer.
// Ports:
//   CLK        : sole clock, all state on posedge
//   RESET      : synchronous active-high reset
//   bus        : mem_arbiter_if.slave (requester and memory signals)
//   DBG_STATE  : current FSM state, for observation only
// FSM: IDLE -> GNT_x (memory command held) -> DONE_x (x_BUSYWAIT low one
// cycle) -> IDLE. The MEM_* command, address and write data are registered at
// grant and held until the memory completes, so requester-side changes during
// a grant never reach the memory port.
// Configuration macro: MEM_ARB_ROUND_ROBIN_EN
//   undefined : fixed priority, D wins a tie, no pointer register
//   defined   : 1-bit last-served pointer, tie goes to the other side;
//               pointer updated on entry to DONE_x, reset to the I side
// -----------------------------------------------------------------------------
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W  = MEM_ARB_ADDR_W,
  parameter int BLOCK_W = MEM_ARB_BLOCK_W
) (
  input  logic       CLK,
  input  logic       RESET,
  mem_arbiter_if.slave bus,
  output arb_state_e DBG_STATE
);

  arb_state_e         state_q;
  logic               mem_read_q;
  logic               mem_write_q;
  logic [ADDR_W-1:0]  mem_addr_q;
  logic [BLOCK_W-1:0] mem_wdata_q;
  logic [BLOCK_W-1:0] i_rdata_q;
  logic [BLOCK_W-1:0] d_rdata_q;

  logic i_req;
  logic d_req;
  logic d_is_write;
  logic last_served;
  logic gnt_valid;
  logic gnt_side;

  assign i_req      = bus.I_READ;
  assign d_req      = bus.D_READ | bus.D_WRITE;
  // A simultaneous D_READ and D_WRITE is a write; the read is ignored.
  assign d_is_write = bus.D_WRITE;

`ifdef MEM_ARB_ROUND_ROBIN_EN
  logic last_q;
  assign last_served = last_q;
`else
  // Pretending the I side was always served last makes D win every tie.
  assign last_served = REQ_I;
`endif

  mem_arb_pick u_pick (
    .i_req_i     (i_req),
    .d_req_i     (d_req),
    .last_i      (last_served),
    .gnt_valid_o (gnt_valid),
    .gnt_side_o  (gnt_side)
  );

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q     <= IDLE;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      i_rdata_q   <= '0;
      d_rdata_q   <= '0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
      last_q      <= REQ_I;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (gnt_valid) begin
            if (gnt_side == REQ_D) begin
              mem_read_q  <= ~d_is_write;
              mem_write_q <= d_is_write;
              mem_addr_q  <= bus.D_ADDR;
              if (d_is_write) begin
                mem_wdata_q <= bus.D_WRITEDATA;
              end
              state_q <= GNT_D;
            end else begin
              mem_read_q  <= 1'b1;
              mem_write_q <= 1'b0;
              mem_addr_q  <= bus.I_ADDR;
              state_q     <= GNT_I;
            end
          end
        end

        GNT_I: begin
          if (!bus.MEM_BUSYWAIT) begin
            if (mem_read_q) begin
              i_rdata_q <= bus.MEM_READDATA;
            end
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            state_q     <= DONE_I;
`ifdef MEM_ARB_ROUND_ROBIN_EN
            last_q      <= REQ_I;
`endif
          end
        end

        GNT_D: begin
          if (!bus.MEM_BUSYWAIT) begin
            // Writes leave D_READDATA untouched.
            if (mem_read_q) begin
              d_rdata_q <= bus.MEM_READDATA;
            end
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            state_q     <= DONE_D;
`ifdef MEM_ARB_ROUND_ROBIN_EN
            last_q      <= REQ_D;
`endif
          end
        end

        DONE_I, DONE_D: begin
          state_q <= IDLE;
        end

        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  // Stall whenever a request is up, except in that side's completion cycle.
  // A withdrawn request simply stops stalling; the transaction still finishes.
  assign bus.I_BUSYWAIT    = i_req && (state_q != DONE_I);
  assign bus.D_BUSYWAIT    = d_req && (state_q != DONE_D);

  assign bus.I_READDATA    = i_rdata_q;
  assign bus.D_READDATA    = d_rdata_q;
  assign bus.MEM_READ      = mem_read_q;
  assign bus.MEM_WRITE     = mem_write_q;
  assign bus.MEM_ADDR      = mem_addr_q;
  assign bus.MEM_WRITEDATA = mem_wdata_q;
  assign DBG_STATE         = state_q;

endmodule
